// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction-fetch front end.
// The queue entry pairs each fetched word with the PC it was fetched from.
package fetch_pkg;

    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_INSTR_WIDTH = 32;
    localparam int MAX_ADDR_WIDTH  = 64;

    typedef struct packed {
        logic [DEF_ADDR_WIDTH-1:0]  pc;
        logic [DEF_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

    // Clears the low log2(pc_step) bits; pc_step must be a power of two.
    function automatic logic [MAX_ADDR_WIDTH-1:0] pc_align_mask(input int unsigned pc_step);
        return ~(MAX_ADDR_WIDTH'(pc_step) - MAX_ADDR_WIDTH'(1));
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries with push/pop/flush and an occupancy count.
// Push into a full queue and pop from an empty queue are ignored; flush wins over both.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  entry_t                   push_entry,
    input  logic                     pop,
    input  logic                     flush,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_push = push && !flush && (count != CNT_W'(DEPTH));
    assign do_pop  = pop && !flush && (count != '0);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, keeps one memory request in flight,
// buffers returned words with their PC, and flushes everything on redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    INSTR_WIDTH  = 32,
    parameter int                    DEPTH        = 4,
    parameter int                    PC_STEP      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic                   clock,
    input  logic                   reset,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ready,
    input  logic                   mem_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] mem_rsp_data,
    input  logic                   redirect_valid,
    input  logic [ADDR_WIDTH-1:0]  redirect_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr_data,
    output logic [ADDR_WIDTH-1:0]  instr_pc
);

    localparam int                        CNT_W           = $clog2(DEPTH) + 1;
    localparam logic [MAX_ADDR_WIDTH-1:0] ALIGN_MASK_FULL = pc_align_mask(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0]     ALIGN_MASK      = ALIGN_MASK_FULL[ADDR_WIDTH-1:0];

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  pc;
        logic [INSTR_WIDTH-1:0] instr;
    } entry_t;

    logic [ADDR_WIDTH-1:0] fetch_pc;
    logic [ADDR_WIDTH-1:0] req_pc;
    logic                  pending;
    logic                  drop;
    logic [CNT_W-1:0]      count;
    logic [CNT_W:0]        occupancy;
    logic                  accept;
    logic                  rsp_fire;
    logic                  push;
    logic                  pop;
    entry_t                push_entry;
    entry_t                head;

    // The in-flight request reserves a slot so the queue can never overflow.
    assign occupancy = {1'b0, count} + (CNT_W + 1)'(pending);
    assign mem_req   = !redirect_valid && (!pending || mem_rsp_valid)
                       && (occupancy < (CNT_W + 1)'(DEPTH));
    assign mem_addr  = fetch_pc;
    assign accept    = mem_req && mem_ready;

    assign rsp_fire   = mem_rsp_valid && pending;
    assign push       = rsp_fire && !drop && !redirect_valid;
    assign push_entry = '{pc: req_pc, instr: mem_rsp_data};

    assign instr_valid = (count != '0) && !redirect_valid;
    assign pop         = instr_valid && instr_ready;
    assign instr_data  = head.instr;
    assign instr_pc    = head.pc;

    fetch_queue #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_queue (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .flush      (redirect_valid),
        .head       (head),
        .count      (count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fetch_pc <= RESET_VECTOR;
            req_pc   <= '0;
            pending  <= 1'b0;
            drop     <= 1'b0;
        end else begin
            if (redirect_valid) begin
                fetch_pc <= redirect_pc & ALIGN_MASK;
            end else if (accept) begin
                fetch_pc <= fetch_pc + ADDR_WIDTH'(PC_STEP);
            end

            if (accept) begin
                req_pc  <= fetch_pc;
                pending <= 1'b1;
            end else if (rsp_fire) begin
                pending <= 1'b0;
            end

            // A redirect with a response still outstanding marks that response stale.
            if (rsp_fire) begin
                drop <= 1'b0;
            end else if (redirect_valid && pending) begin
                drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a memory model answering addr+100 after a chosen
// latency, and an in-order consumer scoreboard expecting a strictly +4 PC stream.
module tb_fetch_unit;

    logic        clock;
    logic        reset;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;

    int checks   = 0;
    int failures = 0;

    // memory model state
    int          lat;
    int          rsp_wait;
    logic        busy;
    logic [31:0] rsp_addr;

    // per-cycle samples and scoreboard
    logic        last_req, last_acc, last_rsp, last_ivalid, last_pop;
    logic [31:0] last_addr, last_pop_pc;
    logic [31:0] exp_pc;
    logic [31:0] exp_data;
    int          n_acc, n_pop;

    fetch_unit dut (
        .clock          (clock),
        .reset          (reset),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample just before the edge, then advance the memory model after it.
    task automatic tick();
        #3;
        last_req    = mem_req;
        last_acc    = mem_req && mem_ready;
        last_addr   = mem_addr;
        last_rsp    = mem_rsp_valid;
        last_ivalid = instr_valid;
        last_pop    = instr_valid && instr_ready;
        last_pop_pc = instr_pc;
        if (last_pop) begin
            exp_data = exp_pc + 32'd100;
            chk("pop_pc", instr_pc, exp_pc);
            chk("pop_data", instr_data, exp_data);
            exp_pc = exp_pc + 32'd4;
            n_pop++;
        end
        if (last_acc) n_acc++;
        @(posedge clock);
        #1;
        if (last_rsp) begin
            mem_rsp_valid = 1'b0;
            busy          = 1'b0;
        end
        if (last_acc) begin
            busy     = 1'b1;
            rsp_addr = last_addr;
            rsp_wait = lat;
        end
        if (busy && !mem_rsp_valid) begin
            rsp_wait--;
            if (rsp_wait == 0) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_data  = rsp_addr + 32'd100;
            end
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        mem_rsp_valid  = 1'b0;
        busy           = 1'b0;
        redirect_valid = 1'b0;
        @(posedge clock);
        #1;
        reset  = 1'b0;
        exp_pc = 32'h0;
    endtask

    initial begin
        reset          = 1'b1;
        mem_ready      = 1'b1;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        instr_ready    = 1'b1;
        lat            = 1;
        busy           = 1'b0;
        rsp_wait       = 0;
        rsp_addr       = '0;
        exp_pc         = '0;
        n_acc          = 0;
        n_pop          = 0;

        // reset state
        #2;
        chk("rst_mem_req", mem_req, 1);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr_data", instr_data, 0);
        chk("rst_instr_pc", instr_pc, 0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // 1-cycle memory streaming
        tick(); chk("s_acc0", last_acc, 1); chk("s_addr0", last_addr, 32'h0);
        chk("s_ivalid0", last_ivalid, 0);
        tick(); chk("s_addr1", last_addr, 32'h4); chk("s_ivalid1", last_ivalid, 0);
        tick(); chk("s_addr2", last_addr, 32'h8); chk("s_pop2", last_pop, 1);
        chk("s_pop2_pc", last_pop_pc, 32'h0);
        tick(); chk("s_addr3", last_addr, 32'hC); chk("s_pop3_pc", last_pop_pc, 32'h4);
        tick(); chk("s_pop4_pc", last_pop_pc, 32'h8);

        // full queue with stalled consumer
        do_reset();
        instr_ready = 1'b0;
        n_acc = 0;
        repeat (8) tick();
        chk("full_accepts", n_acc, 4);
        chk("full_req_low", last_req, 0);
        instr_ready = 1'b1;
        tick(); chk("full_pop", last_pop, 1); chk("full_pop_no_req", last_acc, 0);
        instr_ready = 1'b0;
        tick(); chk("full_refill_acc", last_acc, 1); chk("full_refill_addr", last_addr, 32'h10);
        tick(); chk("full_again_req", last_req, 0);
        instr_ready = 1'b1;
        repeat (6) tick();

        // redirect with a stale request in flight
        do_reset();
        lat = 4;
        repeat (10) tick();
        chk("rd_pre_pending_addr", rsp_addr, 32'h8);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        exp_pc         = 32'h40;
        tick(); chk("rd_cycle_req", last_req, 0); chk("rd_cycle_ivalid", last_ivalid, 0);
        redirect_valid = 1'b0;
        tick(); chk("rd_wait_req", last_req, 0);
        lat = 1;
        tick(); chk("rd_stale_rsp", last_rsp, 1); chk("rd_new_acc", last_acc, 1);
        chk("rd_new_addr", last_addr, 32'h40);
        tick();
        tick(); chk("rd_first_pop", last_pop, 1); chk("rd_first_pc", last_pop_pc, 32'h40);

        // misaligned redirect while the queue is streaming
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        exp_pc         = 32'h40;
        tick(); chk("al_cycle_ivalid", last_ivalid, 0); chk("al_cycle_req", last_req, 0);
        redirect_valid = 1'b0;
        tick(); chk("al_after_ivalid", last_ivalid, 0); chk("al_acc", last_acc, 1);
        chk("al_addr", last_addr, 32'h40);
        repeat (4) tick();

        // random ready / latency
        n_pop = 0;
        for (int i = 0; i < 200; i++) begin
            mem_ready   = 1'($urandom_range(0, 1));
            instr_ready = 1'($urandom_range(0, 1));
            lat         = int'($urandom_range(1, 3));
            tick();
        end
        chk("rand_progress", 64'(n_pop >= 20), 1);
        mem_ready   = 1'b1;
        instr_ready = 1'b1;
        lat         = 1;

        // asynchronous reset with 3 queued entries
        do_reset();
        instr_ready = 1'b0;
        repeat (4) tick();
        chk("pre_rst_valid", instr_valid, 1);
        reset         = 1'b1;
        mem_rsp_valid = 1'b0;
        busy          = 1'b0;
        #1;
        chk("async_rst_ivalid", instr_valid, 0);
        chk("async_rst_addr", mem_addr, 32'h0);
        chk("async_rst_req", mem_req, 1);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // PC wrap
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        exp_pc         = 32'hFFFF_FFFC;
        tick(); chk("wrap_rd_req", last_req, 0);
        redirect_valid = 1'b0;
        tick(); chk("wrap_addr_top", last_addr, 32'hFFFF_FFFC);
        tick(); chk("wrap_addr_zero", last_addr, 32'h0);
        tick(); chk("wrap_pop_pc", last_pop_pc, 32'hFFFF_FFFC);
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
